// File: rtl/h80cpu_uart_tx.sv
// Memory-mapped 8N1 UART transmitter for the h80cpu IO bus: toggle run/done handshake,
// circular TX FIFO and a pollable STATUS register. Bus commands: 1=read_w 2=read_b 3=write_w 4=write_b.
module h80cpu_uart_tx #(
  parameter int CLK_FREQ   = 27000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic [2:0]  cmd,
  input  logic        run,
  input  logic [15:0] wr_data,
  output logic [15:0] rd_data,
  output logic        done,
  output logic        uart_txp
);

  localparam int DIV  = CLK_FREQ / BAUD;
  localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = PW + 1;
  localparam logic [CW-1:0]   BAUD_LAST = CW'(DIV - 1);
  localparam logic [CNTW-1:0] FULL_CNT  = CNTW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    bus_cmd_read_w  = 3'd1,
    bus_cmd_read_b  = 3'd2,
    bus_cmd_write_w = 3'd3,
    bus_cmd_write_b = 3'd4
  } bus_cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          state;
  logic [CW-1:0]   baud_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CNTW-1:0] count;
  logic            overrun;

  logic        pending, is_write, is_read, sel_data, sel_status;
  logic        fifo_empty, fifo_full, baud_last;
  logic        pop, push, push_ok, ovr_set, ovr_clr;
  logic [31:0] count_w;
  logic [3:0]  cnt_sat;
  logic [15:0] status, rd_next;
  logic        unused_ok;

  assign unused_ok = &{1'b0, addr[0], wr_data[15:8]};

  always_comb begin
    pending    = run != done;
    is_write   = (cmd == bus_cmd_write_w) || (cmd == bus_cmd_write_b);
    is_read    = (cmd == bus_cmd_read_w) || (cmd == bus_cmd_read_b);
    sel_data   = addr[15:1] == 15'h0000;
    sel_status = addr[15:1] == 15'h0001;
    fifo_empty = count == '0;
    fifo_full  = count == FULL_CNT;
    baud_last  = baud_cnt == BAUD_LAST;
    pop        = !fifo_empty && ((state == S_IDLE) || ((state == S_STOP) && baud_last));
    push       = pending && is_write && sel_data;
    // A pop in the same cycle frees a slot, so a push to a full FIFO still lands.
    push_ok    = push && (!fifo_full || pop);
    ovr_set    = push && !push_ok;
    ovr_clr    = pending && is_write && sel_status && wr_data[3];
    count_w    = 32'(count);
    cnt_sat    = (count_w > 32'd15) ? 4'hF : count_w[3:0];
    status     = {8'h00, cnt_sat, overrun, state != S_IDLE, fifo_empty, fifo_full};
    rd_next    = (is_read && sel_status) ? status : '0;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      uart_txp <= 1'b1;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overrun  <= 1'b0;
      done     <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (pending) begin
        done    <= ~done;
        rd_data <= rd_next;
      end
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      if (push_ok && !pop)      count <= count + CNTW'(1);
      else if (pop && !push_ok) count <= count - CNTW'(1);
      if (ovr_set)      overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;

      case (state)
        S_IDLE: begin
          if (pop) begin
            state    <= S_START;
            shreg    <= mem[rd_ptr];
            uart_txp <= 1'b0;
            baud_cnt <= '0;
          end
        end
        S_START: begin
          if (baud_last) begin
            state    <= S_DATA;
            uart_txp <= shreg[0];
            shreg    <= shreg >> 1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              state    <= S_STOP;
              uart_txp <= 1'b1;
            end else begin
              bit_cnt  <= bit_cnt + 3'd1;
              uart_txp <= shreg[0];
              shreg    <= shreg >> 1;
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (baud_last) begin
            baud_cnt <= '0;
            // Back-to-back frames: reload straight into START without an idle gap.
            if (pop) begin
              state    <= S_START;
              shreg    <= mem[rd_ptr];
              uart_txp <= 1'b0;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_h80cpu_uart_tx.sv
// Bench for h80cpu_uart_tx: directed and random bus traffic checked against a
// frame-level timing model of the FIFO and line, plus a line decoder.
module tb_h80cpu_uart_tx;
  localparam int unsigned DIV   = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned FRAME = 10 * DIV;
  localparam int unsigned HN    = 8192;
  localparam logic [2:0] C_RW = 3'd1, C_RB = 3'd2, C_WW = 3'd3, C_WB = 3'd4;

  logic        clk = 1'b0, reset = 1'b1, run = 1'b0;
  logic [2:0]  cmd = C_RW;
  logic [15:0] addr = '0, wr_data = '0;
  logic [15:0] rd_data;
  logic        done, uart_txp;

  h80cpu_uart_tx #(.CLK_FREQ(400), .BAUD(100), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .addr(addr), .cmd(cmd), .run(run),
    .wr_data(wr_data), .rd_data(rd_data), .done(done), .uart_txp(uart_txp)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // hist[k] is the line level after posedge number k.
  logic hist [HN];
  logic exp_line [HN];
  always @(negedge clk) if (cyc < HN) hist[cyc] <= uart_txp;

  typedef struct { logic [7:0] b; int unsigned arr; } ent_t;
  ent_t        q[$];
  logic [7:0]  sent[$];
  logic [7:0]  rx[$];
  int unsigned line_free = 0;
  bit          m_ovr = 1'b0;
  int unsigned passed = 0, total = 0;

  // Each queued byte starts its frame at max(previous frame end, arrival+1).
  function automatic void advance(input int unsigned t);
    int unsigned p;
    logic [9:0]  bits;
    while (q.size() > 0) begin
      p = (line_free > q[0].arr + 1) ? line_free : q[0].arr + 1;
      if (p > t) break;
      bits = {1'b1, q[0].b, 1'b0};
      for (int unsigned k = 0; k < 10; k++)
        for (int unsigned j = 0; j < DIV; j++)
          if (p + k * DIV + j < HN) exp_line[p + k * DIV + j] = bits[k];
      sent.push_back(q[0].b);
      line_free = p + FRAME;
      void'(q.pop_front());
    end
  endfunction

  function automatic void m_reset(input int unsigned r);
    advance(r - 1);
    q.delete();
    m_ovr = 1'b0;
    line_free = 0;
    for (int unsigned i = r; i < r + FRAME && i < HN; i++) exp_line[i] = 1'b1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic bus(input logic [2:0] c, input logic [15:0] a, input logic [15:0] d,
                     output logic [15:0] r, output int unsigned e);
    @(negedge clk);
    cmd = c; addr = a; wr_data = d; run = ~run;
    @(posedge clk); #1;
    e = cyc;
    check("done_toggle", {31'b0, done}, {31'b0, run});
    r = rd_data;
  endtask

  task automatic wr(input logic [2:0] c, input logic [15:0] a, input logic [15:0] d,
                    output int unsigned e);
    logic [15:0] r;
    bus(c, a, d, r, e);
    if (a[15:1] == 15'h0) begin
      advance(e);
      if (q.size() < DEPTH) q.push_back('{d[7:0], e});
      else m_ovr = 1'b1;
    end else if (a[15:1] == 15'h1 && d[3]) begin
      m_ovr = 1'b0;
    end
  endtask

  task automatic rd_status(input string tag, input logic [2:0] c, output logic [15:0] r);
    int unsigned e, n;
    logic [15:0] ex;
    logic [3:0]  ns;
    bus(c, 16'h0002, 16'h0000, r, e);
    advance(e - 1);
    n  = q.size();
    ns = (n > 15) ? 4'hF : n[3:0];
    ex = {8'h00, ns, m_ovr, line_free > e - 1, n == 0, n == DEPTH};
    check(tag, {16'h0, r}, {16'h0, ex});
  endtask

  task automatic check_wave(input string tag, input int unsigned from, input int unsigned to);
    int unsigned bad = 0, first = 0;
    for (int unsigned i = from; i < to; i++)
      if (hist[i] !== exp_line[i]) begin
        if (bad == 0) first = i;
        bad++;
      end
    check($sformatf("%s_wave_bad_cycles(first=%0d)", tag, first), bad, 0);
  endtask

  task automatic check_decode(input string tag, input int unsigned from, input int unsigned to);
    int unsigned i = from;
    logic [7:0]  b;
    rx.delete();
    while (i + FRAME <= to) begin
      if (hist[i] === 1'b0) begin
        for (int unsigned k = 0; k < 8; k++) b[k] = hist[i + (k + 1) * DIV + DIV / 2];
        rx.push_back(b);
        i += 9 * DIV + DIV / 2;
      end else begin
        i++;
      end
    end
    check({tag, "_nframes"}, rx.size(), sent.size());
    for (int unsigned k = 0; k < rx.size() && k < sent.size(); k++)
      check($sformatf("%s_byte%0d", tag, k), {24'h0, rx[k]}, {24'h0, sent[k]});
  endtask

  task automatic do_reset(input int unsigned n, output int unsigned r);
    @(negedge clk);
    reset = 1'b1; run = 1'b0;
    r = cyc + 1;
    m_reset(r);
    @(posedge clk); #1;
    check("rst_line", {31'b0, uart_txp}, 32'd1);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_rd_data", {16'h0, rd_data}, 32'd0);
    repeat (n - 1) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [15:0] r;
    logic [9:0]  v;
    int unsigned e, e1, e2, s, rr, op;
    for (int unsigned i = 0; i < HN; i++) exp_line[i] = 1'b1;

    // 1: reset
    repeat (3) @(posedge clk); #1;
    check("reset_line", {31'b0, uart_txp}, 32'd1);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_rd_data", {16'h0, rd_data}, 32'd0);
    @(negedge clk) reset = 1'b0;
    rd_status("reset_status", C_RW, r);
    check("reset_status_const", {16'h0, r}, 32'h0002);

    // 2: single byte 0x55
    s = cyc; sent.delete();
    wr(C_WB, 16'h0000, 16'h0055, e);
    repeat (FRAME + 6) @(posedge clk); #1;
    check("t2_before_pop", {31'b0, hist[e]}, 32'd1);
    for (int unsigned k = 0; k < 10; k++) v[k] = hist[e + 1 + k * DIV];
    check("t2_bits", {22'h0, v}, 32'h2AA);
    check("t2_hold_high", {31'b0, hist[e + 1 + FRAME]}, 32'd1);
    advance(cyc);
    check_wave("t2", s, cyc);
    check_decode("t2", s, cyc);
    rd_status("t2_status", C_RW, r);
    check("t2_status_const", {16'h0, r}, 32'h0002);

    // 3: back-to-back 'H','e'
    s = cyc; sent.delete();
    wr(C_WB, 16'h0000, 16'h0048, e1);
    wr(C_WB, 16'h0000, 16'h0065, e2);
    repeat (2 * FRAME + 6) @(posedge clk); #1;
    check("t3_first_stop", {31'b0, hist[e1 + FRAME]}, 32'd1);
    check("t3_second_start", {31'b0, hist[e1 + 1 + FRAME]}, 32'd0);
    check("t3_idle_after", {31'b0, hist[e1 + 1 + 2 * FRAME]}, 32'd1);
    advance(cyc);
    check_wave("t3", s, cyc);
    check_decode("t3", s, cyc);
    rd_status("t3_status", C_RW, r);
    check("t3_status_const", {16'h0, r}, 32'h0002);

    // 4: overrun burst
    s = cyc; sent.delete();
    for (int i = 0; i < 6; i++) wr(C_WB, 16'h0000, 16'($urandom_range(0, 255)), e);
    rd_status("t4_status", C_RW, r);
    check("t4_full_bit", {31'b0, r[0]}, 32'd1);
    check("t4_ovr_bit", {31'b0, r[3]}, 32'd1);
    wr(C_WW, 16'h0002, 16'h0008, e);
    rd_status("t4_status_clr", C_RB, r);
    check("t4_ovr_cleared", {31'b0, r[3]}, 32'd0);
    repeat (5 * FRAME + 10) @(posedge clk); #1;
    advance(cyc);
    check_wave("t4", s, cyc);
    check_decode("t4", s, cyc);
    check("t4_frames", rx.size(), 32'd5);

    // 5: decode corners
    s = cyc; sent.delete();
    bus(C_RW, 16'h0004, 16'h1234, r, e);
    check("t5_unmapped_rd", {16'h0, r}, 32'd0);
    bus(C_RW, 16'h0000, 16'h0000, r, e);
    check("t5_txdata_rd", {16'h0, r}, 32'd0);
    wr(C_WW, 16'h0010, 16'h00FF, e);
    wr(C_WW, 16'h0001, 16'hABCD, e);
    rd_status("t5_status_b", C_RB, r);
    repeat (FRAME + 10) @(posedge clk); #1;
    advance(cyc);
    check_wave("t5", s, cyc);
    check_decode("t5", s, cyc);
    check("t5_nframes_const", rx.size(), 32'd1);
    for (int unsigned k = 0; k < rx.size(); k++) check("t5_byte_cd", {24'h0, rx[k]}, 32'hCD);

    // random traffic
    s = cyc; sent.delete();
    repeat (60) begin
      op = $urandom_range(0, 9);
      if (op < 6) begin
        wr(($urandom_range(0, 1) != 0) ? C_WW : C_WB,
           (op == 5) ? 16'h0008 : 16'($urandom_range(0, 1)),
           16'($urandom_range(0, 65535)), e);
      end else if (op < 8) begin
        rd_status("rand_status", ($urandom_range(0, 1) != 0) ? C_RW : C_RB, r);
      end else if (op == 8) begin
        wr(C_WB, 16'h0003, 16'h0008, e);
      end else begin
        repeat ($urandom_range(1, 25)) @(posedge clk);
      end
    end
    repeat ((DEPTH + 2) * FRAME) @(posedge clk); #1;
    advance(cyc);
    check_wave("rand", s, cyc);
    check_decode("rand", s, cyc);

    // 6: reset during data bit 3 of 0xA5 (bit 3 is 0)
    s = cyc; sent.delete();
    wr(C_WB, 16'h0000, 16'h00A5, e);
    repeat (17) @(posedge clk);
    do_reset(2, rr);
    check("t6_low_before_reset", {31'b0, hist[rr - 1]}, 32'd0);
    rd_status("t6_status", C_RW, r);
    check("t6_status_const", {16'h0, r}, 32'h0002);
    repeat (2 * FRAME) @(posedge clk); #1;
    advance(cyc);
    check_wave("t6", s, cyc);
    sent.delete();
    check_decode("t6_after_reset", rr, cyc);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
